// File: rtl/led_counter_ctl_pkg.sv
// Shared definitions for the LED counter controller.
//   - Button indices into the 4-bit BTTN bus.
//   - Encodings of the MODE and DIR status outputs.
package led_counter_ctl_pkg;

  localparam int NUM_BTN  = 4;

  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_DIR  = 2;
  localparam int BTN_CLR  = 3;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pb_sync_debounce.sv
// Push-button synchroniser and debouncer.
// A 2-FF synchroniser feeds a stability counter. The accepted state flips only
// after the synchronised input has disagreed with it for 2**DB_BITS
// consecutive cycles. The latency from a clean raw edge to the flip is
// 2 + 2**DB_BITS cycles.
// Ports:
//   CLK       in  system clock
//   RST_N     in  synchronous active-low reset
//   PB        in  raw asynchronous button, active-high
//   PB_state  out debounced level (0 = released)
//   PB_down   out one-cycle pulse on the 0->1 flip of PB_state
//   PB_up     out one-cycle pulse on the 1->0 flip of PB_state
module pb_sync_debounce #(
  parameter int DB_BITS = 5
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PB,
  output logic PB_state,
  output logic PB_down,
  output logic PB_up
);

  logic               sync1_q, sync2_q;
  logic               state_q, state_d;
  logic               down_q, up_q;
  logic [DB_BITS-1:0] cnt_q, cnt_d;
  logic               flip;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    flip    = 1'b0;
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (&cnt_q) begin
        flip    = 1'b1;
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of the others (the synchroniser chain depends on this).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      sync1_q <= PB;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      down_q  <= flip & ~state_q;
      up_q    <= flip & state_q;
    end
  end

  assign PB_state = state_q;
  assign PB_down  = down_q;
  assign PB_up    = up_q;

endmodule

// File: rtl/led_counter_ctl.sv
// LED counter controller: modulo-MODULUS up/down counter in free-run or
// single-step mode, driving binary and Gray LED banks and an activity
// indicator. Single clock; the prescaler and debouncers only produce enables.
// Ports:
//   CLK        in  system clock
//   RST_N      in  synchronous active-low reset
//   BTTN[3:0]  in  raw buttons: [0] step, [1] mode, [2] direction, [3] clear
//   LEDS       out binary count (registered)
//   LEDS_Gray  out Gray code of the count
//   ACT_LED    out activity indicator, active-low
//   MODE       out 0 = run, 1 = step
//   DIR        out 0 = up, 1 = down
//   WRAP       out one-cycle pulse when the count wraps
module led_counter_ctl
  import led_counter_ctl_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int DIV_BITS = 23,
  parameter int DB_BITS  = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       BTTN,
  output logic [WIDTH-1:0] LEDS,
  output logic [WIDTH-1:0] LEDS_Gray,
  output logic [2:0]       ACT_LED,
  output logic             MODE,
  output logic             DIR,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [NUM_BTN-1:0] pb_state, pb_down, pb_up;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    pb_sync_debounce #(.DB_BITS(DB_BITS)) u_db (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .PB       (BTTN[b]),
      .PB_state (pb_state[b]),
      .PB_down  (pb_down[b]),
      .PB_up    (pb_up[b])
    );
  end

  // Only the clear level and the press pulses are consumed here.
  logic unused_pb;
  assign unused_pb = ^{pb_up, pb_state[BTN_DIR:BTN_STEP]};

  logic [DIV_BITS-1:0] div_q;
  logic [2:0]          act_q;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                wrap_q, wrap_d;
  mode_e               mode_q, mode_d;
  dir_e                dir_q, dir_d;
  logic                run_tick, count_ev;

  assign run_tick = &div_q;

  // Count event and toggles all look at the registered MODE/DIR, so a toggle
  // landing in the same cycle as a count event only affects later events.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    count_ev = (mode_q == MODE_RUN) ? run_tick : pb_down[BTN_STEP];
    if (pb_state[BTN_CLR]) begin
      count_d = '0;
    end else if (count_ev) begin
      if (dir_q == DIR_UP) begin
        if (count_q == MAX_CNT) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
    mode_d = pb_down[BTN_MODE] ? mode_e'(~mode_q) : mode_q;
    dir_d  = pb_down[BTN_DIR]  ? dir_e'(~dir_q)   : dir_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_q   <= '0;
      act_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= MODE_RUN;
      dir_q   <= DIR_UP;
    end else begin
      div_q   <= div_q + 1'b1;
      if (run_tick) act_q <= act_q + 1'b1;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign LEDS      = count_q;
  assign LEDS_Gray = count_q ^ (count_q >> 1);
  assign ACT_LED   = {~act_q[0], ~act_q[1], ~act_q[2]};
  assign MODE      = mode_q;
  assign DIR       = dir_q;
  assign WRAP      = wrap_q;

endmodule

// File: tb/tb_led_counter_ctl.sv
module tb_led_counter_ctl;

  localparam int W          = 4;
  localparam int MOD        = 10;
  localparam int DIVB       = 4;
  localparam int DBB        = 2;
  localparam int DIV_PERIOD = 2 ** DIVB;
  localparam int DBN        = 2 ** DBB;

  logic         CLK;
  logic         RST_N;
  logic [3:0]   BTTN;
  logic [W-1:0] LEDS, LEDS_Gray;
  logic [2:0]   ACT_LED;
  logic         MODE, DIR, WRAP;

  led_counter_ctl #(
    .WIDTH(W), .MODULUS(MOD), .DIV_BITS(DIVB), .DB_BITS(DBB)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTTN      (BTTN),
    .LEDS      (LEDS),
    .LEDS_Gray (LEDS_Gray),
    .ACT_LED   (ACT_LED),
    .MODE      (MODE),
    .DIR       (DIR),
    .WRAP      (WRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] leds;
    logic [W-1:0] gray;
    logic [2:0]   act_led;
    logic         mode;
    logic         dir;
    logic         wrap;
  } exp_t;

  exp_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int wrap_seen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: behaviour expressed as "button accepted once the last
  // 2**DB_BITS synchronised samples all disagree", a cycle counter for the
  // prescaler and modulo arithmetic for the count.
  int       m_count, m_act, m_n;
  bit       m_mode, m_dir, m_wrap;
  bit [3:0] m_state, m_down;
  bit       hist [4][DBN+1];

  task automatic model_step();
    exp_t     e;
    bit       tick, ev, all_diff;
    bit [3:0] dn;
    bit [2:0] a;
    if (!RST_N) begin
      m_count = 0; m_act = 0; m_n = 0;
      m_mode = 0; m_dir = 0; m_wrap = 0;
      m_state = '0; m_down = '0;
      for (int b = 0; b < 4; b++)
        for (int i = 0; i <= DBN; i++) hist[b][i] = 1'b0;
    end else begin
      m_n++;
      tick   = (m_n % DIV_PERIOD) == 0;
      ev     = m_mode ? m_down[0] : tick;
      m_wrap = 1'b0;
      if (m_state[3]) m_count = 0;
      else if (ev) begin
        if (!m_dir) begin
          m_wrap  = (m_count == MOD - 1);
          m_count = (m_count + 1) % MOD;
        end else begin
          m_wrap  = (m_count == 0);
          m_count = (m_count + MOD - 1) % MOD;
        end
      end
      if (m_down[1]) m_mode = !m_mode;
      if (m_down[2]) m_dir  = !m_dir;
      if (tick) m_act = (m_act + 1) % 8;
      dn = '0;
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int i = 1; i <= DBN; i++)
          if (hist[b][i] == m_state[b]) all_diff = 1'b0;
        dn[b] = all_diff && !m_state[b];
        if (all_diff) m_state[b] = !m_state[b];
      end
      m_down = dn;
      for (int b = 0; b < 4; b++) begin
        for (int i = DBN; i >= 1; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = BTTN[b];
      end
    end
    a         = 3'(m_act);
    e.leds    = W'(m_count);
    e.gray    = W'(m_count ^ (m_count >> 1));
    e.act_led = {~a[0], ~a[1], ~a[2]};
    e.mode    = m_mode;
    e.dir     = m_dir;
    e.wrap    = m_wrap;
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("leds",    32'(LEDS),      32'(e.leds));
      check("gray",    32'(LEDS_Gray), 32'(e.gray));
      check("act_led", 32'(ACT_LED),   32'(e.act_led));
      check("mode",    32'(MODE),      32'(e.mode));
      check("dir",     32'(DIR),       32'(e.dir));
      check("wrap",    32'(WRAP),      32'(e.wrap));
      if (WRAP === 1'b1) wrap_seen++;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic press(input int btn);
    BTTN[btn] = 1'b1;
    tick_n(10);
    BTTN[btn] = 1'b0;
    tick_n(10);
  endtask

  initial begin
    logic [3:0] b;
    int         wrap_base;
    RST_N = 1'b0;
    BTTN  = '0;

    // Reset values
    tick_n(3);
    check("rst_leds", 32'(LEDS), 0);
    check("rst_gray", 32'(LEDS_Gray), 0);
    check("rst_act",  32'(ACT_LED), 32'h7);
    check("rst_mode", 32'(MODE), 0);
    check("rst_dir",  32'(DIR), 0);
    check("rst_wrap", 32'(WRAP), 0);
    RST_N = 1'b1;

    // Free run up: 10 ticks in 160 cycles, 9 -> 0 wrap on the last one
    wrap_base = wrap_seen;
    repeat (160) @(posedge CLK);
    @(negedge CLK);
    check("run_leds",  32'(LEDS), 0);
    check("run_wrap",  32'(WRAP), 1);
    check("run_act",   32'(ACT_LED), 32'h5);
    check("run_wraps", 32'(wrap_seen - wrap_base), 1);
    @(posedge CLK);
    #1;

    // Bouncing direction button, then a clean hold
    for (int i = 0; i < 10; i++) begin
      BTTN[2] = ~BTTN[2];
      tick_n(2);
    end
    BTTN[2] = 1'b1;
    tick_n(12);
    check("bounce_dir", 32'(DIR), 1);
    BTTN[2] = 1'b0;
    tick_n(10);

    // Step mode: clear to 0, then three steps down -> 7, frozen on run ticks
    press(1);
    check("step_mode", 32'(MODE), 1);
    press(3);
    press(0); press(0); press(0);
    check("step3_leds", 32'(LEDS), 7);
    tick_n(64);
    check("step_hold", 32'(LEDS), 7);

    // Clear held across run ticks and across a step press
    press(1);
    BTTN[3] = 1'b1;
    tick_n(8);
    wrap_base = wrap_seen;
    tick_n(40);
    BTTN[1] = 1'b1; tick_n(10); BTTN[1] = 1'b0; tick_n(10);
    BTTN[0] = 1'b1; tick_n(10); BTTN[0] = 1'b0; tick_n(10);
    check("clr_leds",  32'(LEDS), 0);
    check("clr_wraps", 32'(wrap_seen - wrap_base), 0);
    BTTN[3] = 1'b0;
    tick_n(10);
    press(0);
    check("clr_resume", 32'(LEDS), 9);
    press(0); press(0); press(0); press(0);
    check("pre_rst_leds", 32'(LEDS), 5);

    // Reset with the step button half-debounced
    BTTN[0] = 1'b1;
    tick_n(3);
    RST_N = 1'b0;
    tick_n(1);
    check("mid_rst_leds", 32'(LEDS), 0);
    check("mid_rst_dir",  32'(DIR), 0);
    check("mid_rst_act",  32'(ACT_LED), 32'h7);
    tick_n(1);
    RST_N = 1'b1;
    tick_n(5);
    BTTN = '0;
    tick_n(10);

    // Randomised button activity with occasional resets
    for (int it = 0; it < 300; it++) begin
      b = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) b[3] = 1'b1;
      BTTN = b;
      tick_n($urandom_range(1, 14));
      if ($urandom_range(0, 39) == 0) begin
        RST_N = 1'b0;
        tick_n($urandom_range(1, 3));
        RST_N = 1'b1;
      end
    end
    BTTN = '0;

    repeat (2) @(negedge CLK);
    #1;
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
